// File: rtl/br_ckpt_ctrl.sv
// Single-checkpoint branch controller for the rename map table.
// Sequences checkpoint begin/commit/restore and throttles dispatch around them.
module br_ckpt_ctrl #(
    parameter int ROB_TAG_LEN    = 5,
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   dispatch_valid,
    input  logic                   dispatch_is_branch,
    input  logic [ROB_TAG_LEN-1:0] dispatch_rob_tag,
    output logic                   dispatch_stall,
    input  logic                   ex_br_valid,
    input  logic [ROB_TAG_LEN-1:0] ex_br_rob_tag,
    input  logic                   ex_br_mispredict,
    input  logic [31:0]            ex_br_target,
    input  logic                   ext_flush,
    output logic                   branch_detected,
    output logic                   resolve,
    output logic                   kill,
    output logic                   squash_valid,
    output logic [ROB_TAG_LEN-1:0] squash_rob_tag,
    output logic                   redirect_valid,
    output logic [31:0]            redirect_pc,
    output logic                   branch_pending,
    output logic [CNT_W-1:0]       branch_count,
    output logic [CNT_W-1:0]       mispredict_count
);

    localparam int RW = $clog2(RECOVER_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        RECOVER
    } state_t;

    state_t                 state;
    logic [ROB_TAG_LEN-1:0] br_tag;
    logic [RW-1:0]          rcnt;
    logic                   match;

    // Pulses are combinational so the map table sees them on the rename edge.
    always_comb begin
        match           = 1'b0;
        dispatch_stall  = 1'b0;
        branch_detected = 1'b0;
        resolve         = 1'b0;
        kill            = 1'b0;
        squash_valid    = 1'b0;
        squash_rob_tag  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        branch_pending  = (state == PENDING);
        if (ext_flush) begin
            dispatch_stall = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    branch_detected = dispatch_valid && dispatch_is_branch;
                end
                PENDING: begin
                    match = ex_br_valid && (ex_br_rob_tag == br_tag);
                    // Renames on a commit/restore edge would miss the checkpoint.
                    dispatch_stall = dispatch_is_branch || match;
                    resolve        = match && !ex_br_mispredict;
                    kill           = match && ex_br_mispredict;
                    squash_valid   = kill;
                    redirect_valid = kill;
                    if (kill) begin
                        squash_rob_tag = br_tag;
                        redirect_pc    = ex_br_target;
                    end
                end
                RECOVER: begin
                    dispatch_stall = 1'b1;
                end
                default: begin
                    dispatch_stall = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            br_tag           <= '0;
            rcnt             <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (ext_flush) begin
            state <= IDLE;
            rcnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (branch_detected) begin
                        br_tag <= dispatch_rob_tag;
                        state  <= PENDING;
                        if (branch_count != '1)
                            branch_count <= branch_count + CNT_W'(1);
                    end
                end
                PENDING: begin
                    if (resolve) begin
                        state <= IDLE;
                    end else if (kill) begin
                        if (mispredict_count != '1)
                            mispredict_count <= mispredict_count + CNT_W'(1);
                        if (RECOVER_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= RECOVER;
                            rcnt  <= RW'(RECOVER_CYCLES);
                        end
                    end
                end
                RECOVER: begin
                    if (rcnt <= RW'(1)) begin
                        state <= IDLE;
                        rcnt  <= '0;
                    end else begin
                        rcnt <= rcnt - RW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/br_ckpt_ctrl.md
Name: br_ckpt_ctrl

Overview:
- Controller for the rename map table's single branch checkpoint.
- Sequences the map table's checkpoint-control inputs: branch_detected, resolve and kill.
- Throttles dispatch so only one unresolved branch is in flight, and freezes dispatch around checkpoint commit/restore edges.
- On a mispredict, drives the squash and PC-redirect signals to the ROB/RS/fetch.

Parameters:
- ROB_TAG_LEN, 5, ROB tag width.
- RECOVER_CYCLES, 2, dispatch-freeze cycles after a kill (0 allowed).
- CNT_W, 16, width of performance counters.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_valid  in  1  an instruction is presented at dispatch this cycle
- dispatch_is_branch  in  1  the presented instruction is a conditional branch or jump
- dispatch_rob_tag  in  ROB_TAG_LEN  ROB entry allocated to the presented instruction
- dispatch_stall  out  1  dispatch must not fire this cycle
- ex_br_valid  in  1  branch resolution from execute
- ex_br_rob_tag  in  ROB_TAG_LEN  ROB tag of the resolving branch
- ex_br_mispredict  in  1  the resolving branch was mispredicted
- ex_br_target  in  32  correct next PC
- ext_flush  in  1  global pipeline flush (exception/ROB flush)
- branch_detected  out  1  to map table: begin checkpoint
- resolve  out  1  to map table: commit checkpoint
- kill  out  1  to map table: restore checkpoint
- squash_valid  out  1  squash all entries younger than squash_rob_tag
- squash_rob_tag  out  ROB_TAG_LEN  tag of the mispredicted branch
- redirect_valid  out  1  fetch redirect
- redirect_pc  out  32  redirect target
- branch_pending  out  1  a checkpointed branch is unresolved
- branch_count  out  CNT_W  branches dispatched (saturating)
- mispredict_count  out  CNT_W  kills issued (saturating)

Behaviour:
- Reset:
  - State is IDLE; the stored tag, recovery counter and both perf counters clear to 0.
  - All outputs are 0, except dispatch_stall, which is 0 in IDLE.
- States: IDLE, PENDING, RECOVER.
- All control outputs are combinational from the current state and the current-cycle inputs. Zero-latency pulses are mandatory: the map table must see branch_detected on the same edge the branch's rename write occurs.
- A dispatch "fires" when dispatch_valid && !dispatch_stall.

IDLE:
- dispatch_stall = 0.
- If a branch fires:
  - branch_detected = 1 for that cycle.
  - Latch dispatch_rob_tag into br_tag.
  - Increment branch_count.
  - Next state is PENDING.

PENDING:
- branch_pending = 1.
- dispatch_stall = dispatch_is_branch (second branch blocked) OR a matching resolution this cycle.
- Matching resolution means ex_br_valid && ex_br_rob_tag == br_tag.
  - Correct prediction: resolve = 1 for one cycle, next state IDLE.
  - Mispredict:
    - kill = 1, squash_valid = 1, squash_rob_tag = br_tag, redirect_valid = 1, redirect_pc = ex_br_target, all for one cycle.
    - Increment mispredict_count.
    - Next state is RECOVER with counter = RECOVER_CYCLES, or IDLE if RECOVER_CYCLES == 0.
- Non-matching ex_br_valid is ignored.
- Rationale for stalling in the resolve/kill cycle: the map table copies its pre-edge contents into the checkpoint and ignores checkpoint writes while a branch is pending, so a rename on that edge would be lost from the checkpoint.

RECOVER:
- dispatch_stall = 1.
- The counter decrements each cycle; when it reaches 1, next state is IDLE.
- ex_br inputs are ignored.

Exclusivity:
- branch_detected, resolve and kill are mutually exclusive by construction; at most one is high in any cycle.

ext_flush:
- Highest priority in every state.
- Next state is IDLE and dispatch_stall = 1 that cycle.
- No branch_detected, resolve, kill, squash or redirect pulse that cycle; the flush owner handles map table state.
- Counters are unchanged.

Counters:
- Saturate at all-ones; no wrap.

Reset mid-operation:
- Reset dominates everything, including a simultaneous resolution.

Test Plan:
- Branch dispatched in IDLE with tag 5 -> branch_detected = 1 in the same cycle, branch_pending = 1 next cycle, branch_count = 1.
- In PENDING, a non-branch dispatches, then ex_br (tag 5, mispredict = 0) arrives -> resolve = 1 and dispatch_stall = 1 that cycle; IDLE next cycle; kill never asserted.
- In PENDING (tag 7), ex_br tag 7 with mispredict = 1 and target 0x0000_1040 -> kill = 1, squash_rob_tag = 7, redirect_pc = 0x1040 for one cycle. dispatch_stall stays high for exactly 2 more cycles (RECOVER_CYCLES = 2), then IDLE. mispredict_count = 1.
- In PENDING (tag 3), a second branch is presented -> dispatch_stall = 1. ex_br with tag 4 -> no pulse, state still PENDING.
- ext_flush asserted in the same cycle as a matching mispredict -> no kill or redirect, IDLE next cycle, counters unchanged.
- Preload branch_count to 0xFFFF via 65535 branch/resolve pairs, then one more branch -> count stays 0xFFFF. Reset asserted during RECOVER -> all outputs 0, IDLE next cycle.
